// File: rtl/quadrature_decode_multi.sv
// Multi-channel quadrature decoder: 2-flop sync, per-channel glitch filter, x1/x2/x4 counting, dir and sticky err.
// Latency FILTER+2 cycles from pin change to count update; no backpressure. Index zeroing built only with QDEC_INDEX_EN.
module quadrature_decode_multi #(
    parameter int WIDTH  = 8,
    parameter int NCH    = 1,
    parameter int FILTER = 2,
    parameter int MODE   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       a,
    input  logic [NCH-1:0]       b,
    input  logic [NCH-1:0]       z,
    input  logic                 clr,
    input  logic                 err_clr,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       dir,
    output logic [NCH-1:0]       err
);

`ifdef QDEC_INDEX_EN
    localparam int SW = 3;
`else
    localparam int SW = 2;
    logic unused_z;
    assign unused_z = ^z;
`endif
    localparam logic [4:0] FLT = 5'(FILTER);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [SW-1:0]    raw, s1, s2, prev, acc;
        logic [3:0]       fc;
        logic             primed;
        logic [WIDTH-1:0] cnt;
        logic             dir_q, err_q;
        logic [4:0]       run;
        logic             active, take, ev, counted, inc, dec, dbl, idx0;
        logic [1:0]       qo, qn, dq;

`ifdef QDEC_INDEX_EN
        assign raw = {a[i], b[i], z[i]};
`else
        assign raw = {a[i], b[i]};
`endif

        // Before priming every stable value is a candidate, so the reset value of acc is never trusted.
        always_comb begin
            active  = !primed || (s2 != acc);
            run     = (fc != 4'd0 && s2 == prev) ? {1'b0, fc} + 5'd1 : 5'd1;
            take    = active && (run >= FLT);
            ev      = take && primed;
            qo      = {acc[SW-1], acc[SW-1] ^ acc[SW-2]};
            qn      = {s2[SW-1], s2[SW-1] ^ s2[SW-2]};
            dq      = qn - qo;
            case (MODE)
                4:       counted = 1'b1;
                2:       counted = acc[SW-1] != s2[SW-1];
                default: counted = !acc[SW-1] && s2[SW-1];
            endcase
            inc     = ev && counted && (dq == 2'd1);
            dec     = ev && counted && (dq == 2'd3);
            dbl     = ev && (dq == 2'd2);
`ifdef QDEC_INDEX_EN
            idx0    = ev && !acc[0] && s2[0];
`else
            idx0    = 1'b0;
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1     <= '0;
                s2     <= '0;
                prev   <= '0;
                acc    <= '0;
                fc     <= '0;
                primed <= 1'b0;
                cnt    <= '0;
                dir_q  <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                s1   <= raw;
                s2   <= s1;
                prev <= s2;
                fc   <= (active && !take) ? run[3:0] : 4'd0;
                if (take) begin
                    acc    <= s2;
                    primed <= 1'b1;
                end
                if (clr || idx0)
                    cnt <= '0;
                else if (inc)
                    cnt <= cnt + WIDTH'(1);
                else if (dec)
                    cnt <= cnt - WIDTH'(1);
                if (!clr && !idx0 && (inc || dec))
                    dir_q <= inc;
                if (dbl)
                    err_q <= 1'b1;
                else if (err_clr)
                    err_q <= 1'b0;
            end
        end

        assign count[i*WIDTH +: WIDTH] = cnt;
        assign dir[i]                  = dir_q;
        assign err[i]                  = err_q;
    end

endmodule

// File: tb/tb_quadrature_decode_multi.sv
// Bench for quadrature_decode_multi: x4 two-channel, x2 and x1 instances share channel-0 pins;
// a position model driven by the quadrant table predicts counts, dir and err.
module tb_quadrature_decode_multi;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] a_in, b_in, z_in;
    logic       clr, err_clr;
    logic [15:0] count4;
    logic [1:0]  dir4, err4;
    logic [7:0]  count2, count1;
    logic        dir2, dir1, err2, err1;

    always #5 clk = ~clk;

    quadrature_decode_multi #(.WIDTH(8), .NCH(2), .FILTER(2), .MODE(4)) u_x4 (
        .clk(clk), .rst_n(rst_n), .a(a_in), .b(b_in), .z(z_in), .clr(clr), .err_clr(err_clr),
        .count(count4), .dir(dir4), .err(err4));
    quadrature_decode_multi #(.WIDTH(8), .NCH(1), .FILTER(2), .MODE(2)) u_x2 (
        .clk(clk), .rst_n(rst_n), .a(a_in[0:0]), .b(b_in[0:0]), .z(z_in[0:0]), .clr(clr),
        .err_clr(err_clr), .count(count2), .dir(dir2), .err(err2));
    quadrature_decode_multi #(.WIDTH(8), .NCH(1), .FILTER(2), .MODE(1)) u_x1 (
        .clk(clk), .rst_n(rst_n), .a(a_in[0:0]), .b(b_in[0:0]), .z(z_in[0:0]), .clr(clr),
        .err_clr(err_clr), .count(count1), .dir(dir1), .err(err1));

    int n_chk = 0;
    int n_err = 0;

    // Reference model: accepted phase per channel and expected outputs of each instance.
    logic [1:0] ph  [2];
    logic [7:0] m4  [2];
    logic       md4 [2];
    logic       me4 [2];
    logic [7:0] m2, m1;
    logic       md2, md1;
    int         qtab [4] = '{0, 1, 3, 2};
    logic [1:0] up_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] walk_ab  [5] = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b00};
    int         walk_cnt [5] = '{2, 3, 4, 3, 4};
    logic       walk_dir [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_step(input int ch, input logic [1:0] nab);
        int   d;
        logic up, a_old, a_new;
        d     = (qtab[nab] - qtab[ph[ch]] + 4) % 4;
        a_old = ph[ch][1];
        a_new = nab[1];
        if (d == 2) begin
            me4[ch] = 1'b1;
        end else if (d != 0) begin
            up      = (d == 1);
            m4[ch]  = up ? m4[ch] + 8'd1 : m4[ch] - 8'd1;
            md4[ch] = up;
            if (ch == 0 && a_old != a_new) begin
                m2  = up ? m2 + 8'd1 : m2 - 8'd1;
                md2 = up;
            end
            if (ch == 0 && !a_old && a_new) begin
                m1  = up ? m1 + 8'd1 : m1 - 8'd1;
                md1 = up;
            end
        end
        ph[ch] = nab;
    endfunction

    task automatic check_all(input string t);
        chk({t, ".cnt0"}, 32'(count4[7:0]), 32'(m4[0]));
        chk({t, ".cnt1"}, 32'(count4[15:8]), 32'(m4[1]));
        chk({t, ".dir4"}, 32'(dir4), 32'({md4[1], md4[0]}));
        chk({t, ".err4"}, 32'(err4), 32'({me4[1], me4[0]}));
        chk({t, ".cnt_x2"}, 32'(count2), 32'(m2));
        chk({t, ".cnt_x1"}, 32'(count1), 32'(m1));
        chk({t, ".dir_x21"}, 32'({dir2, dir1}), 32'({md2, md1}));
        chk({t, ".err_x21"}, 32'({err2, err1}), 32'({me4[0], me4[0]}));
    endtask

    task automatic move(input logic [1:0] ab0, input logic [1:0] ab1);
        @(negedge clk);
        a_in = {ab1[1], ab0[1]};
        b_in = {ab1[0], ab0[0]};
        repeat (5) @(negedge clk);
        model_step(0, ab0);
        model_step(1, ab1);
    endtask

    task automatic glitch(input logic [1:0] ab0, input logic [1:0] ab1);
        @(negedge clk);
        a_in = {ab1[1], ab0[1]};
        b_in = {ab1[0], ab0[0]};
        @(negedge clk);
        a_in = {ph[1][1], ph[0][1]};
        b_in = {ph[1][0], ph[0][0]};
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m4 = '{8'd0, 8'd0};
        m2 = 8'd0;
        m1 = 8'd0;
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        me4 = '{1'b0, 1'b0};
    endtask

    int         r;
    logic [1:0] n0, n1;
    logic       sd4, sd2, sd1;

    initial begin
        a_in = '0; b_in = '0; z_in = '0; clr = 1'b0; err_clr = 1'b0;
        ph = '{2'b00, 2'b00}; m4 = '{8'd0, 8'd0}; md4 = '{1'b0, 1'b0}; me4 = '{1'b0, 1'b0};
        m2 = 8'd0; m1 = 8'd0; md2 = 1'b0; md1 = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // First step: count must hold through edge 3 and move on edge 4.
        a_in[0] = 1'b0;
        b_in[0] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            chk($sformatf("latency_edge%0d", e), 32'(count4[7:0]), (e == 4) ? 32'd1 : 32'd0);
        end
        repeat (2) @(negedge clk);
        model_step(0, 2'b01);
        check_all("first_step");

        for (int i = 0; i < 5; i++) begin
            move(walk_ab[i], 2'b00);
            chk($sformatf("walk%0d_cnt", i), 32'(count4[7:0]), 32'(walk_cnt[i]));
            chk($sformatf("walk%0d_dir", i), 32'(dir4[0]), 32'(walk_dir[i]));
            check_all("walk");
        end

        glitch(2'b10, 2'b00);
        check_all("glitch");
        move(2'b11, 2'b00);
        chk("double_err", 32'(err4[0]), 32'd1);
        chk("double_cnt", 32'(count4[7:0]), 32'd4);
        check_all("double");
        pulse_err_clr();
        chk("err_clr", 32'(err4[0]), 32'd0);
        check_all("err_clr");

        pulse_clr();
        move(2'b01, 2'b00);
        chk("wrap_down", 32'(count4[7:0]), 32'd255);
        move(2'b11, 2'b00);
        chk("wrap_up", 32'(count4[7:0]), 32'd0);
        check_all("wrap");

        move(2'b10, 2'b00);
        move(2'b00, 2'b00);
        pulse_clr();
        for (int i = 0; i < 12; i++) move(up_seq[(i + 1) % 4], 2'b00);
        chk("mode1_cnt", 32'(count1), 32'd3);
        chk("mode2_cnt", 32'(count2), 32'd6);
        chk("mode4_cnt", 32'(count4[7:0]), 32'd12);
        check_all("modes");

        pulse_clr();
        for (int i = 0; i < 5; i++)
            move(up_seq[(i + 1) % 4], (i < 2) ? up_seq[(4 - (i + 1)) % 4] : ph[1]);
        chk("dual_ch0", 32'(count4[7:0]), 32'd5);
        chk("dual_ch1", 32'(count4[15:8]), 32'd254);
        check_all("dual");
        pulse_clr();
        chk("clr_both", 32'(count4), 32'd0);
        check_all("clr");

`ifdef QDEC_INDEX_EN
        move(2'b11, ph[1]);
        sd4 = md4[0]; sd2 = md2; sd1 = md1;
        @(negedge clk);
        z_in[0] = 1'b1;
        a_in[0] = 1'b1;
        b_in[0] = 1'b0;
        repeat (5) @(negedge clk);
        model_step(0, 2'b10);
        m4[0] = 8'd0; m2 = 8'd0; m1 = 8'd0;
        md4[0] = sd4; md2 = sd2; md1 = sd1;
        chk("index_zero", 32'(count4[7:0]), 32'd0);
        check_all("index");
        @(negedge clk);
        z_in[0] = 1'b0;
        repeat (6) @(negedge clk);
        check_all("index_fall");
`else
        sd4 = 1'b0; sd2 = 1'b0; sd1 = 1'b0;
`endif

        for (int it = 0; it < 60; it++) begin
            r  = $urandom_range(0, 9);
            n0 = 2'($urandom_range(0, 3));
            n1 = 2'($urandom_range(0, 3));
            if (r < 7) move(n0, n1);
            else if (r == 7) glitch(n0, n1);
            else if (r == 8) pulse_clr();
            else pulse_err_clr();
            check_all($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
